// File: rtl/single_port_sync_ram_pkg.sv
// Shared types and defaults for the single-port synchronous RAM controller.
package single_port_sync_ram_pkg;

  // Default geometry, kept in step with the RAM instance.
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 16;

  // Encoding of req_write.
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Burst controller states.
  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WFLUSH,
    READ,
    RDRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/single_port_sync_ram_ctrl_if.sv
// Client-side request, write-stream and read-stream signals of the burst controller.
interface single_port_sync_ram_ctrl_if
  import single_port_sync_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [ADDR_WIDTH:0]   req_len;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  done;

  // Client datapath side.
  modport master (
    output req_valid, req_write, req_addr, req_len, wr_data, wr_valid,
    input  req_ready, wr_ready, rd_data, rd_valid, done
  );

  // Controller side.
  modport slave (
    input  req_valid, req_write, req_addr, req_len, wr_data, wr_valid,
    output req_ready, wr_ready, rd_data, rd_valid, done
  );

endinterface

// File: rtl/sram_bus_drv.sv
// Tristate driver for the shared RAM data bus: holds the accepted write word
// and only drives the bus while a RAM write cycle is on the pins.
module sram_bus_drv #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  drive_i,
  inout  wire  [DATA_WIDTH-1:0] bus_io
);

  logic [DATA_WIDTH-1:0] data_q;

  // Capture the write word in the same edge that registers the write pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= data_i;
    end
  end

  assign bus_io = drive_i ? data_q : {DATA_WIDTH{1'bz}};

endmodule

// File: rtl/single_port_sync_ram_ctrl.sv
// Initiator-side burst controller for the single-port synchronous RAM.
// Turns write bursts into RAM write cycles and read bursts into a registered
// read-data stream; all RAM pins are registered.
module single_port_sync_ram_ctrl
  import single_port_sync_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  single_port_sync_ram_ctrl_if.slave client,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  inout  wire  [DATA_WIDTH-1:0]   mem_data,
  output logic                    mem_cs,
  output logic                    mem_we,
  output logic                    mem_oe
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   LEN_ONE   = (ADDR_WIDTH+1)'(1);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] curAddr_q;
  logic [ADDR_WIDTH:0]   remaining_q;
  logic [ADDR_WIDTH-1:0] memAddr_q;
  logic                  memCs_q;
  logic                  memWe_q;
  logic                  memOe_q;
  logic                  done_q;
  logic                  rdPend_q;
  logic                  rdValid_q;
  logic [DATA_WIDTH-1:0] rdData_q;

  logic [ADDR_WIDTH-1:0] curAddrNext_d;
  logic [ADDR_WIDTH-1:0] reqAddrNext_d;
  logic [ADDR_WIDTH:0]   remainingDec_d;
  logic                  reqReady;
  logic                  wrReady;
  logic                  wrAccept;

  // Address increments wrap at the last RAM word; length counts down by one word.
  always_comb begin
    curAddrNext_d  = (curAddr_q == LAST_ADDR) ? '0 : curAddr_q + ADDR_WIDTH'(1);
    reqAddrNext_d  = (client.req_addr == LAST_ADDR) ? '0 : client.req_addr + ADDR_WIDTH'(1);
    remainingDec_d = remaining_q - LEN_ONE;
  end

  assign reqReady = rst_n && (state_q == IDLE);
  assign wrReady  = (state_q == WRITE) && (remaining_q != '0);
  assign wrAccept = wrReady && client.wr_valid;

  // Burst FSM, counters, registered RAM pins and the two-stage read return path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      curAddr_q   <= '0;
      remaining_q <= '0;
      memAddr_q   <= '0;
      memCs_q     <= 1'b0;
      memWe_q     <= 1'b0;
      memOe_q     <= 1'b0;
      done_q      <= 1'b0;
      rdPend_q    <= 1'b0;
      rdValid_q   <= 1'b0;
      rdData_q    <= '0;
    end else begin
      done_q    <= 1'b0;
      rdPend_q  <= (state_q == READ);
      rdValid_q <= rdPend_q;
      if (rdPend_q) begin
        rdData_q <= mem_data;
      end

      case (state_q)
        IDLE: begin
          memCs_q <= 1'b0;
          memWe_q <= 1'b0;
          memOe_q <= 1'b0;
          if (client.req_valid && reqReady) begin
            if (client.req_len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (client.req_write == OP_WRITE) begin
              state_q     <= WRITE;
              curAddr_q   <= client.req_addr;
              remaining_q <= client.req_len;
            end else begin
              state_q     <= READ;
              memCs_q     <= 1'b1;
              memOe_q     <= 1'b1;
              memAddr_q   <= client.req_addr;
              curAddr_q   <= reqAddrNext_d;
              remaining_q <= client.req_len - LEN_ONE;
            end
          end
        end

        WRITE: begin
          if (wrAccept) begin
            memCs_q     <= 1'b1;
            memWe_q     <= 1'b1;
            memOe_q     <= 1'b0;
            memAddr_q   <= curAddr_q;
            curAddr_q   <= curAddrNext_d;
            remaining_q <= remainingDec_d;
            if (remaining_q == LEN_ONE) begin
              state_q <= WFLUSH;
            end
          end else begin
            memCs_q <= 1'b0;
            memWe_q <= 1'b0;
          end
        end

        WFLUSH: begin
          memCs_q <= 1'b0;
          memWe_q <= 1'b0;
          memOe_q <= 1'b0;
          state_q <= DONE;
          done_q  <= 1'b1;
        end

        READ: begin
          if (remaining_q != '0) begin
            memAddr_q   <= curAddr_q;
            curAddr_q   <= curAddrNext_d;
            remaining_q <= remainingDec_d;
          end else begin
            state_q <= RDRAIN;
          end
        end

        RDRAIN: begin
          memCs_q <= 1'b0;
          memOe_q <= 1'b0;
          state_q <= DONE;
          done_q  <= 1'b1;
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
          memCs_q <= 1'b0;
          memWe_q <= 1'b0;
          memOe_q <= 1'b0;
        end
      endcase
    end
  end

  sram_bus_drv #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_bus_drv (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (wrAccept),
    .data_i (client.wr_data),
    .drive_i(memCs_q && memWe_q),
    .bus_io (mem_data)
  );

  assign client.req_ready = reqReady;
  assign client.wr_ready  = wrReady;
  assign client.rd_data   = rdData_q;
  assign client.rd_valid  = rdValid_q;
  assign client.done      = done_q;

  assign mem_addr = memAddr_q;
  assign mem_cs   = memCs_q;
  assign mem_we   = memWe_q;
  assign mem_oe   = memOe_q;

endmodule

// File: doc/single_port_sync_ram_ctrl.md
Name: single_port_sync_ram_ctrl

Overview:
- Initiator-side burst controller for the single-port synchronous RAM.
- Drives the RAM pin interface: address, shared tristate data bus, chip select, write enable and output enable.
- Converts a burst request plus streamed write data into RAM write cycles.
- Converts a burst read request into RAM read cycles and returns a registered read-data stream.
- Sits between a client datapath and the RAM instance.

Parameters:
- ADDR_WIDTH, 4, RAM address width. DEPTH must equal 2**ADDR_WIDTH.
- DATA_WIDTH, 32, RAM word width.
- DEPTH, 16, number of RAM words.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  burst request valid.
- req_ready  out  1  high only in IDLE.
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_WIDTH  burst start address.
- req_len  in  ADDR_WIDTH+1  word count, 0..DEPTH.
- wr_data  in  DATA_WIDTH  write stream data.
- wr_valid  in  1  write stream valid.
- wr_ready  out  1  controller accepts a write word.
- rd_data  out  DATA_WIDTH  read word, registered.
- rd_valid  out  1  rd_data valid for one cycle; no backpressure.
- done  out  1  one-cycle pulse at burst completion.
- mem_addr  out  ADDR_WIDTH  RAM address, registered.
- mem_data  inout  DATA_WIDTH  RAM data bus; driven only while mem_cs & mem_we, else high-Z.
- mem_cs  out  1  RAM chip select, registered.
- mem_we  out  1  RAM write enable, registered.
- mem_oe  out  1  RAM output enable, registered.

Behaviour:
- Reset values: req_ready=0 during reset, 1 in the first cycle after reset. All other outputs 0. mem_data is high-Z. State = IDLE; address and length counters cleared.
- States: IDLE, WRITE, WFLUSH, READ, RDRAIN, DONE.
- IDLE:
  - req_valid & req_ready at an edge latches addr and len.
  - If len=0, go to DONE with no RAM access.
  - Otherwise go to WRITE or READ according to req_write.
- WRITE:
  - wr_ready = (remaining != 0).
  - On each wr_valid & wr_ready edge, the next cycle has mem_cs=1, mem_we=1, mem_oe=0, mem_addr=cur, and mem_data driven with the accepted word. Then cur++ and remaining--.
  - Cycles with no handshake drop mem_cs/mem_we to 0 in the next cycle (bubble).
  - After the last accept, go to WFLUSH. The last RAM write occurs in WFLUSH; the RAM commits it at the end of that cycle. Then go to DONE.
- READ:
  - Each cycle drives mem_cs=1, mem_we=0, mem_oe=1, mem_addr=cur; cur++ and remaining--.
  - After the last address cycle, go to RDRAIN for exactly one cycle. Pins stay cs=1, oe=1, we=0 with the address held; this re-read is harmless.
  - Read latency: the address is presented in cycle t; the RAM bus is valid in t+1 and sampled at the end of t+1; rd_valid/rd_data appear in t+2.
  - Words return in address order; count equals len exactly.
- DONE: done=1 for one cycle, all mem pins deasserted, then go to IDLE. In read bursts, done coincides with the last rd_valid.
- Latency from the request-accept edge:
  - Read of L words: address cycles 1..L, rd_valid cycles 3..L+2, done in cycle L+2.
  - Write with wr_valid held high: writes in cycles 2..L+1, done in cycle L+2.
- Address arithmetic: cur wraps modulo DEPTH (DEPTH-1 -> 0). len=DEPTH touches every word once.
- Bus rules:
  - The controller never drives mem_data while mem_we=0.
  - IDLE/DONE give at least one cycle with mem_cs=0 between consecutive bursts, which provides bus turnaround.
- Request input: req_valid outside IDLE is ignored (not queued).
- Write stream: wr_valid in READ or IDLE is ignored; wr_ready stays 0.
- Reset mid-burst: at the next edge, return to IDLE, deassert all mem pins, release the bus, and drop the remaining words. No done pulse; rd_valid=0.

Decomposition:
- Package single_port_sync_ram_pkg holds:
  - the state enum (IDLE..DONE);
  - op constants OP_READ=0 and OP_WRITE=1;
  - default width localparams shared with the RAM.
- One natural sub-module: sram_bus_drv, the tristate driver for mem_data (output register + enable = mem_cs & mem_we).
- The FSM and counters stay in the top module.

Test Plan:
- Write burst addr=2, len=4, data 0xA0..0xA3 with wr_valid held high, then read burst addr=2, len=4 -> rd_data 0xA0, 0xA1, 0xA2, 0xA3 on 4 consecutive cycles. done coincides with the 4th rd_valid; mem_data is never driven by the controller during the read.
- Wrap: write addr=14, len=4 with 0x1..0x4 -> RAM[14]=1, [15]=2, [0]=3, [1]=4; read-back matches in order.
- Write stream bubbles: wr_valid pattern 1,0,0,1,1 for len=3 -> mem_we pulses appear only after accepted beats, addresses are consecutive, and done fires 2 cycles after the last accept.
- len=0 read and len=0 write -> done 1 cycle after accept; mem_cs stays 0; no rd_valid.
- rst_n low for 1 cycle in the middle of a len=8 read -> all mem pins 0 and bus high-Z the next cycle, no done, no rd_valid; req_ready=1 the cycle after reset is released.
- Back-to-back write len=1 then read len=1 at the same address, value 0xDEADBEEF -> at least one mem_cs=0 cycle between bursts; rd_data=0xDEADBEEF.
